alu_arbiter: RTL and testbench

//  Shares the single ALU between two requesters: req0 is calculator_core and req1 is a

---
 rtl/alu_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU: fair grant, one operation in flight,
// result routed back to the issuer, and a watchdog for an unresponsive ALU.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_r0_a,
  input  logic [DATA_WIDTH-1:0] i_r0_b,
  input  logic [1:0]            i_r0_op,
  input  logic                  i_r0_signed,
  input  logic                  i_r0_valid,
  output logic                  o_r0_ready,
  output logic [DATA_WIDTH-1:0] o_r0_result,
  output logic                  o_r0_error,
  output logic                  o_r0_result_valid,
  input  logic                  i_r0_result_ready,
  input  logic [DATA_WIDTH-1:0] i_r1_a,
  input  logic [DATA_WIDTH-1:0] i_r1_b,
  input  logic [1:0]            i_r1_op,
  input  logic                  i_r1_signed,
  input  logic                  i_r1_valid,
  output logic                  o_r1_ready,
  output logic [DATA_WIDTH-1:0] o_r1_result,
  output logic                  o_r1_error,
  output logic                  o_r1_result_valid,
  input  logic                  i_r1_result_ready,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [1:0]            o_alu_op,
  output logic                  o_alu_signed,
  output logic                  o_alu_valid,
  input  logic                  i_alu_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic                  o_alu_result_ready,
  output logic                  o_busy,
  output logic                  o_owner
);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  stale_q, stale_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic                  alu_valid_q, alu_valid_d;
  logic                  alu_rready_q, alu_rready_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  busy_q, busy_d;
  logic                  win_c, grant_c, rsp_ready_c;

  // On a tie the requester that was not served last wins
  always_comb begin
    if (i_r0_valid && i_r1_valid) win_c = ~last_q;
    else                          win_c = ~i_r0_valid;
    grant_c = (state_q == S_IDLE) && !stale_q && !rst && (i_r0_valid || i_r1_valid);
  end

  assign o_r0_ready = grant_c && !win_c;
  assign o_r1_ready = grant_c && win_c;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    stale_d     = stale_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sgn_d       = sgn_q;
    res0_d      = res0_q;
    res1_d      = res1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rsp_ready_c = owner_q ? i_r1_result_ready : i_r0_result_ready;

    // A late response from a timed-out operation is swallowed here
    if (stale_q && i_alu_result_valid) stale_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_c) begin
          owner_d = win_c;
          a_d     = win_c ? i_r1_a : i_r0_a;
          b_d     = win_c ? i_r1_b : i_r0_b;
          op_d    = win_c ? i_r1_op : i_r0_op;
          sgn_d   = win_c ? i_r1_signed : i_r0_signed;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_alu_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_alu_result_valid) begin
          if (owner_q) begin
            res1_d = i_alu_result;
            err1_d = i_alu_error;
          end else begin
            res0_d = i_alu_result;
            err0_d = i_alu_error;
          end
          state_d = S_RETURN;
        end else if (WDOG_EN && (cnt_q >= CNT_W'(CNT_LIM))) begin
          if (owner_q) begin
            res1_d = '0;
            err1_d = 1'b1;
          end else begin
            res0_d = '0;
            err0_d = 1'b1;
          end
          stale_d = 1'b1;
          state_d = S_RETURN;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RETURN: begin
        if (rsp_ready_c) begin
          last_d  = owner_q;
          res0_d  = '0;
          res1_d  = '0;
          err0_d  = 1'b0;
          err1_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    alu_valid_d  = (state_d == S_ISSUE);
    alu_rready_d = (state_d == S_WAIT) || stale_d;
    rvalid0_d    = (state_d == S_RETURN) && !owner_d;
    rvalid1_d    = (state_d == S_RETURN) && owner_d;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      stale_q      <= 1'b0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      sgn_q        <= 1'b0;
      res0_q       <= '0;
      res1_q       <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      alu_valid_q  <= 1'b0;
      alu_rready_q <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      stale_q      <= stale_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      sgn_q        <= sgn_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      alu_valid_q  <= alu_valid_d;
      alu_rready_q <= alu_rready_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      busy_q       <= busy_d;
    end
  end

  assign o_r0_result        = res0_q;
  assign o_r0_error         = err0_q;
  assign o_r0_result_valid  = rvalid0_q;
  assign o_r1_result        = res1_q;
  assign o_r1_error         = err1_q;
  assign o_r1_result_valid  = rvalid1_q;
  assign o_alu_a            = a_q;
  assign o_alu_b            = b_q;
  assign o_alu_op           = op_q;
  assign o_alu_signed       = sgn_q;
  assign o_alu_valid        = alu_valid_q;
  assign o_alu_result_ready = alu_rready_q;
  assign o_busy             = busy_q;
  assign o_owner            = owner_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, tie/timeout/reset sequences,
// and randomized traffic against an order-and-arithmetic reference model.
module tb_alu_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    op;
    logic          sgn;
  } req_t;

  typedef struct {
    bit          who;
    req_t        rq;
    logic [DW:0] want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] i_r0_a, i_r0_b, i_r1_a, i_r1_b;
  logic [1:0]    i_r0_op, i_r1_op;
  logic          i_r0_signed, i_r0_valid, i_r0_result_ready;
  logic          i_r1_signed, i_r1_valid, i_r1_result_ready;
  logic          o_r0_ready, o_r0_error, o_r0_result_valid;
  logic          o_r1_ready, o_r1_error, o_r1_result_valid;
  logic [DW-1:0] o_r0_result, o_r1_result;
  logic [DW-1:0] o_alu_a, o_alu_b;
  logic [1:0]    o_alu_op;
  logic          o_alu_signed, o_alu_valid, i_alu_ready;
  logic [DW-1:0] i_alu_result;
  logic          i_alu_error, i_alu_result_valid, o_alu_result_ready;
  logic          o_busy, o_owner;

  int checks = 0;
  int errors = 0;
  bit last_owner;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_r0_a(i_r0_a), .i_r0_b(i_r0_b), .i_r0_op(i_r0_op), .i_r0_signed(i_r0_signed),
    .i_r0_valid(i_r0_valid), .o_r0_ready(o_r0_ready), .o_r0_result(o_r0_result),
    .o_r0_error(o_r0_error), .o_r0_result_valid(o_r0_result_valid),
    .i_r0_result_ready(i_r0_result_ready),
    .i_r1_a(i_r1_a), .i_r1_b(i_r1_b), .i_r1_op(i_r1_op), .i_r1_signed(i_r1_signed),
    .i_r1_valid(i_r1_valid), .o_r1_ready(o_r1_ready), .o_r1_result(o_r1_result),
    .o_r1_error(o_r1_error), .o_r1_result_valid(o_r1_result_valid),
    .i_r1_result_ready(i_r1_result_ready),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_signed(o_alu_signed),
    .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready), .i_alu_result(i_alu_result),
    .i_alu_error(i_alu_error), .i_alu_result_valid(i_alu_result_valid),
    .o_alu_result_ready(o_alu_result_ready), .o_busy(o_busy), .o_owner(o_owner)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference ALU: 0 add, 1 sub, 2 mul, 3 div (divide by zero -> error, result 0)
  function automatic logic [DW:0] alu_ref(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic sgn);
    longint x, y, r;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: begin
        if (y == 0) return {1'b1, {DW{1'b0}}};
        r = x / y;
      end
    endcase
    return {1'b0, r[DW-1:0]};
  endfunction

  function automatic req_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [1:0] op, input logic sgn);
    req_t r;
    r.a = a; r.b = b; r.op = op; r.sgn = sgn;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.a   = DW'($urandom);
    r.b   = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
    r.op  = 2'($urandom);
    r.sgn = 1'($urandom);
    return r;
  endfunction

  function automatic logic [DW:0] ref_of(input req_t r);
    return alu_ref(r.op, r.a, r.b, r.sgn);
  endfunction

  task automatic drive(input bit who, input req_t r);
    if (who) begin
      i_r1_a = r.a; i_r1_b = r.b; i_r1_op = r.op; i_r1_signed = r.sgn; i_r1_valid = 1'b1;
    end else begin
      i_r0_a = r.a; i_r0_b = r.b; i_r0_op = r.op; i_r0_signed = r.sgn; i_r0_valid = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'(|{o_r0_ready, o_r1_ready, o_r0_result, o_r1_result, o_r0_error, o_r1_error,
                      o_r0_result_valid, o_r1_result_valid, o_alu_a, o_alu_b, o_alu_op,
                      o_alu_signed, o_alu_valid, o_alu_result_ready, o_busy, o_owner}), 64'd0);
  endtask

  // Runs one transaction for winner w; entered at a negedge with requests driven
  task automatic serve(input bit w, input req_t rq, input logic [DW:0] want, input int ia_dly,
                       input int lat, input int rr_dly, input bit tmo);
    logic [DW:0] alu_out;
    int n;
    #1;
    check("winner_ready", 64'(w ? o_r1_ready : o_r0_ready), 64'd1);
    check("loser_ready", 64'(w ? o_r0_ready : o_r1_ready), 64'd0);
    @(negedge clk);
    if (w) i_r1_valid = 1'b0; else i_r0_valid = 1'b0;
    check("alu_valid", 64'(o_alu_valid), 64'd1);
    check("alu_operands", 64'({o_alu_a, o_alu_b, o_alu_op, o_alu_signed}),
          64'({rq.a, rq.b, rq.op, rq.sgn}));
    check("owner", 64'(o_owner), 64'(w));
    alu_out = alu_ref(o_alu_op, o_alu_a, o_alu_b, o_alu_signed);
    repeat (ia_dly) @(negedge clk);
    check("alu_valid_held", 64'(o_alu_valid), 64'd1);
    i_alu_ready = 1'b1;
    @(negedge clk);
    i_alu_ready = 1'b0;
    check("wait_state", 64'({o_alu_valid, o_alu_result_ready, o_busy}), 64'b011);
    if (tmo) begin
      n = 0;
      while (o_r0_result_valid !== 1'b1 && o_r1_result_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("timeout_reached", 64'(n < 40), 64'd1);
    end else begin
      repeat (lat) @(negedge clk);
      i_alu_result_valid = 1'b1;
      i_alu_result       = alu_out[DW-1:0];
      i_alu_error        = alu_out[DW];
      @(negedge clk);
      i_alu_result_valid = 1'b0;
      i_alu_result       = DW'($urandom);
      i_alu_error        = 1'b0;
    end
    check("owner_rvalid", 64'(w ? o_r1_result_valid : o_r0_result_valid), 64'd1);
    check("result", 64'({w ? o_r1_error : o_r0_error, w ? o_r1_result : o_r0_result}), 64'(want));
    check("other_side", 64'({w ? o_r0_result_valid : o_r1_result_valid,
                             w ? o_r0_error : o_r1_error}), 64'd0);
    check("alu_rready_return", 64'(o_alu_result_ready), 64'(tmo));
    for (int i = 0; i < rr_dly; i++) begin
      @(negedge clk);
      check("hold_owner", 64'({w ? o_r1_result_valid : o_r0_result_valid,
                               w ? o_r1_result : o_r0_result,
                               w ? o_r1_error : o_r0_error, o_busy}),
            64'({1'b1, want[DW-1:0], want[DW], 1'b1}));
      check("hold_other", 64'({w ? o_r0_result_valid : o_r1_result_valid, o_r0_ready, o_r1_ready}),
            64'd0);
    end
    if (w) i_r1_result_ready = 1'b1; else i_r0_result_ready = 1'b1;
    @(negedge clk);
    i_r0_result_ready = 1'b0;
    i_r1_result_ready = 1'b0;
    check("back_idle", 64'({o_r0_result_valid, o_r1_result_valid, o_busy}), 64'd0);
    last_owner = w;
  endtask

  vec_t vecs[7];
  req_t rq0, rq1, pend_rq[2];
  bit   pend[2];
  bit   w;
  int   it;

  initial begin
    vecs[0] = '{1'b0, mk(16'd7, 16'd5, 2'd0, 1'b0), {1'b0, 16'd12}};
    vecs[1] = '{1'b1, mk(16'd10, 16'd3, 2'd1, 1'b0), {1'b0, 16'd7}};
    vecs[2] = '{1'b0, mk(16'd9, 16'd0, 2'd3, 1'b0), {1'b1, 16'h0000}};
    vecs[3] = '{1'b1, mk(16'd300, 16'd300, 2'd2, 1'b0), {1'b0, 16'h5F90}};
    vecs[4] = '{1'b0, mk(16'hFFF8, 16'd2, 2'd3, 1'b1), {1'b0, 16'hFFFC}};
    vecs[5] = '{1'b1, mk(16'hFFF8, 16'd2, 2'd3, 1'b0), {1'b0, 16'h7FFC}};
    vecs[6] = '{1'b0, mk(16'd3, 16'd5, 2'd1, 1'b0), {1'b0, 16'hFFFE}};

    rst = 1'b1;
    {i_r0_a, i_r0_b, i_r0_op, i_r0_signed, i_r0_valid, i_r0_result_ready} = '0;
    {i_r1_a, i_r1_b, i_r1_op, i_r1_signed, i_r1_valid, i_r1_result_ready} = '0;
    {i_alu_ready, i_alu_result, i_alu_error, i_alu_result_valid} = '0;
    last_owner = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // Ties straight after reset: r0 first, then strict alternation
    rq0 = mk(16'd1, 16'd2, 2'd0, 1'b0);
    rq1 = mk(16'd100, 16'd30, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rq0);
      drive(1'b1, rq1);
      serve(i[0], i[0] ? rq1 : rq0, i[0] ? ref_of(rq1) : ref_of(rq0), 0, 1, 0, 1'b0);
    end
    serve(1'b0, rq0, ref_of(rq0), 0, 0, 0, 1'b0);

    // Directed single-requester vectors
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].who, vecs[i].rq);
      serve(vecs[i].who, vecs[i].rq, vecs[i].want, 0, 0, 1, 1'b0);
    end

    // r1 result held off 10 cycles while r0 waits
    rq0 = mk(16'd4, 16'd4, 2'd2, 1'b0);
    drive(1'b0, rq0);
    serve(1'b0, rq0, ref_of(rq0), 0, 0, 0, 1'b0);
    rq0 = mk(16'h1234, 16'h0101, 2'd0, 1'b0);
    rq1 = mk(16'h8000, 16'hFFFF, 2'd2, 1'b1);
    drive(1'b0, rq0);
    drive(1'b1, rq1);
    serve(1'b1, rq1, ref_of(rq1), 1, 2, 10, 1'b0);
    serve(1'b0, rq0, ref_of(rq0), 0, 0, 0, 1'b0);

    // Watchdog: silent ALU, then a late response must be dropped before the next grant
    rq0 = mk(16'd55, 16'd66, 2'd0, 1'b0);
    drive(1'b0, rq0);
    serve(1'b0, rq0, {1'b1, {DW{1'b0}}}, 0, 0, 2, 1'b1);
    rq1 = mk(16'd20, 16'd4, 2'd3, 1'b0);
    drive(1'b1, rq1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stale_blocks_grant", 64'({o_r1_ready, o_alu_result_ready, o_busy}), 64'b010);
      @(negedge clk);
    end
    i_alu_result_valid = 1'b1;
    i_alu_result       = 16'hBEEF;
    @(negedge clk);
    i_alu_result_valid = 1'b0;
    serve(1'b1, rq1, {1'b0, 16'd5}, 0, 1, 0, 1'b0);

    // Randomized traffic against the ordering model
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    it = 0;
    while (it < 60 || pend[0] || pend[1]) begin
      if (it < 60) begin
        for (int k = 0; k < 2; k++) begin
          if (!pend[k] && $urandom_range(0, 1) == 1) begin
            pend_rq[k] = rand_req();
            pend[k]    = 1'b1;
            drive(k[0], pend_rq[k]);
          end
        end
        if (!pend[0] && !pend[1]) begin
          w          = 1'($urandom);
          pend_rq[w] = rand_req();
          pend[w]    = 1'b1;
          drive(w, pend_rq[w]);
        end
      end
      w = (pend[0] && pend[1]) ? !last_owner : pend[1];
      serve(w, pend_rq[w], ref_of(pend_rq[w]), $urandom_range(0, 2), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'b0);
      pend[w] = 1'b0;
      it++;
    end

    // Reset while waiting on the ALU abandons the operation
    rq0 = mk(16'd9, 16'd9, 2'd0, 1'b0);
    drive(1'b0, rq0);
    @(negedge clk);
    i_r0_valid  = 1'b0;
    i_alu_ready = 1'b1;
    @(negedge clk);
    i_alu_ready = 1'b0;
    check("pre_reset_wait", 64'({o_alu_result_ready, o_busy}), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_in_wait");
    @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b0;
    last_owner = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset_release");
    rq1 = mk(16'd40, 16'd2, 2'd1, 1'b0);
    drive(1'b1, rq1);
    serve(1'b1, rq1, {1'b0, 16'd38}, 0, 0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
